// File: rtl/mips_cpu_fetch.sv
// Instruction fetch and PC sequencing for the Harvard MIPS core.
// Fetches one word, holds it for execution, then applies branch/jump decisions with one delay slot.
module mips_cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        branch,
    input  logic        cond,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic        stall,
    output logic        active
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        pending_q, pending_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_read_q, imem_read_d;
    logic        active_q, active_d;

    logic [31:0] p4_s;
    logic        redirect_s;
    logic [31:0] redirect_target_s;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] seq_pc, input logic [25:0] idx);
        return {seq_pc[31:28], idx, 2'b00};
    endfunction

    // Redirect decode: jump_reg outranks jump, which outranks a taken branch.
    always_comb begin
        p4_s              = pc_q + 32'd4;
        redirect_s        = 1'b0;
        redirect_target_s = p4_s;
        if (jump_reg) begin
            redirect_s        = 1'b1;
            redirect_target_s = reg_target;
        end else if (jump) begin
            redirect_s        = 1'b1;
            redirect_target_s = jump_target(p4_s, instr_q[25:0]);
        end else if (branch && cond) begin
            redirect_s        = 1'b1;
            redirect_target_s = p4_s + branch_offset(instr_q[15:0]);
        end else begin
            redirect_s        = 1'b0;
            redirect_target_s = p4_s;
        end
    end

    // Next-state and next-output computation for the fetch/execute sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        pending_d     = pending_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_read_d   = imem_read_q;
        active_d      = active_q;
        case (state_q)
            S_FETCH: begin
                // imem_read_q gates acceptance so the post-reset idle cycle never latches data.
                if (imem_read_q && !imem_waitrequest) begin
                    instr_d       = imem_readdata;
                    instr_valid_d = 1'b1;
                    imem_read_d   = 1'b0;
                    state_d       = S_EXEC;
                end else begin
                    instr_valid_d = 1'b0;
                    imem_read_d   = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC: begin
                if (stall) begin
                    state_d = S_EXEC;
                end else begin
                    instr_valid_d = 1'b0;
                    imem_read_d   = 1'b1;
                    state_d       = S_FETCH;
                    if (pending_q) begin
                        // Delay slot done: take the saved target, ignoring any new request.
                        pc_d      = target_q;
                        pending_d = 1'b0;
                        if (target_q == HALT_ADDR) begin
                            state_d     = S_HALTED;
                            imem_read_d = 1'b0;
                            active_d    = 1'b0;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else if (redirect_s) begin
                        target_d  = redirect_target_s;
                        pending_d = 1'b1;
                        pc_d      = p4_s;
                    end else begin
                        pc_d = p4_s;
                    end
                end
            end
            S_HALTED: begin
                instr_valid_d = 1'b0;
                imem_read_d   = 1'b0;
                active_d      = 1'b0;
                state_d       = S_HALTED;
            end
            default: begin
                instr_valid_d = 1'b0;
                imem_read_d   = 1'b0;
                pending_d     = 1'b0;
                state_d       = S_FETCH;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_VECTOR;
            target_q      <= 32'd0;
            pending_q     <= 1'b0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_read_q   <= 1'b0;
            active_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            pending_q     <= pending_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_read_q   <= imem_read_d;
            active_q      <= active_d;
        end
    end

    assign imem_address = {pc_q[31:2], 2'b00};
    assign imem_read    = imem_read_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign pc           = pc_q;
    assign link_addr    = pc_q + 32'd8;
    assign active       = active_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Bench for mips_cpu_fetch: directed scenarios followed by randomized instruction streams
// checked against an instruction-level model of PC sequencing with a delay slot.
module tb_mips_cpu_fetch;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest = 1'b0;
    logic [31:0] imem_readdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        branch = 1'b0;
    logic        cond = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] reg_target = 32'd0;
    logic        stall = 1'b0;
    logic        active;

    mips_cpu_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_address     (imem_address),
        .imem_read        (imem_read),
        .imem_waitrequest (imem_waitrequest),
        .imem_readdata    (imem_readdata),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .link_addr        (link_addr),
        .branch           (branch),
        .cond             (cond),
        .jump             (jump),
        .jump_reg         (jump_reg),
        .reg_target       (reg_target),
        .stall            (stall),
        .active           (active)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int unsigned exec_cyc = 0;

    // Architectural model: address of next instruction, saved redirect target, delay-slot flag.
    logic [31:0] m_pc = RV;
    logic [31:0] m_tgt = 32'd0;
    bit          m_pend = 1'b0;
    bit          m_halt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic clear_ctl();
        branch = 1'b0; cond = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        reg_target = 32'd0; stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        imem_waitrequest = 1'b0;
        clear_ctl();
        #1;
        chk("rst_pc", pc, RV);
        chk("rst_instr", instr, 32'd0);
        chkb("rst_valid", instr_valid, 1'b0);
        chkb("rst_read", imem_read, 1'b0);
        chkb("rst_active", active, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = RV; m_tgt = 32'd0; m_pend = 1'b0; m_halt = 1'b0;
    endtask

    task automatic wait_read();
        int n;
        n = 0;
        while (imem_read !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        chkb("fetch_req", imem_read, 1'b1);
    endtask

    // One instruction: fetch with `waits` wait states, execute with `stalls` stall cycles.
    task automatic run_instr(input logic [31:0] iw, input bit br, input bit cd, input bit jp,
                             input bit jr, input logic [31:0] rt, input int waits, input int stalls);
        logic [31:0] p4;
        logic [31:0] tgt;
        int          off;
        bit          redir;
        wait_read();
        chk("fetch_addr", imem_address, {m_pc[31:2], 2'b00});
        imem_readdata = iw;
        imem_waitrequest = (waits > 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chkb("wait_read", imem_read, 1'b1);
            chk("wait_addr", imem_address, {m_pc[31:2], 2'b00});
            chkb("wait_novalid", instr_valid, 1'b0);
        end
        imem_waitrequest = 1'b0;
        @(negedge clk);
        exec_cyc = cyc;
        chkb("exec_valid", instr_valid, 1'b1);
        chkb("exec_noread", imem_read, 1'b0);
        chk("exec_instr", instr, iw);
        chk("exec_pc", pc, m_pc);
        chk("exec_link", link_addr, m_pc + 32'd8);
        branch = br; cond = cd; jump = jp; jump_reg = jr; reg_target = rt;
        stall = (stalls > 0);
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            chkb("stall_valid", instr_valid, 1'b1);
            chkb("stall_noread", imem_read, 1'b0);
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, iw);
        end
        stall = 1'b0;
        @(negedge clk);
        clear_ctl();
        p4 = m_pc + 32'd4;
        if (m_pend) begin
            m_pc = m_tgt;
            m_pend = 1'b0;
            m_halt = (m_tgt == 32'd0);
        end else begin
            redir = 1'b1;
            tgt = p4;
            if (jr) tgt = rt;
            else if (jp) tgt = {p4[31:28], iw[25:0], 2'b00};
            else if (br && cd) begin
                off = $signed(iw[15:0]);
                tgt = p4 + 32'(off * 4);
            end else redir = 1'b0;
            if (redir) begin
                m_tgt = tgt;
                m_pend = 1'b1;
            end
            m_pc = p4;
        end
        chkb("post_novalid", instr_valid, 1'b0);
        chkb("post_active", active, !m_halt);
    endtask

    task automatic check_halted(input int n);
        for (int i = 0; i < n; i++) begin
            chkb("halt_active", active, 1'b0);
            chkb("halt_noread", imem_read, 1'b0);
            chkb("halt_novalid", instr_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e0;
        int unsigned e1;
        logic [31:0] iw;
        bit br, cd, jp, jr;
        logic [31:0] rt;

        // Sequential zero-wait fetches: one executed instruction every two cycles.
        do_reset();
        run_instr(32'h00000020, 0, 0, 0, 0, 32'd0, 0, 0);
        e0 = exec_cyc;
        run_instr(32'h00221820, 0, 0, 0, 0, 32'd0, 0, 0);
        e1 = exec_cyc;
        chk("cadence_1", e1 - e0, 32'd2);
        run_instr(32'h00432020, 0, 0, 0, 0, 32'd0, 0, 0);
        chk("cadence_2", exec_cyc - e1, 32'd2);
        chk("seq_pc3", m_pc, 32'hBFC0000C);

        // Wait states on the first fetch.
        do_reset();
        run_instr(32'h00000020, 0, 0, 0, 0, 32'd0, 3, 0);

        // Taken beq, delay slot, jal, delay slot with ignored branch, then reset mid-wait.
        do_reset();
        run_instr(32'h10000003, 1, 1, 0, 0, 32'd0, 0, 0);
        run_instr(32'h00000000, 0, 0, 0, 0, 32'd0, 0, 0);
        wait_read();
        chk("beq_target", imem_address, 32'hBFC00010);
        run_instr(32'h0C000100, 0, 0, 1, 0, 32'd0, 0, 0);
        chk("jal_link_pc", m_pc - 32'd4, 32'hBFC00010);
        run_instr(32'h1000FFF0, 1, 1, 0, 0, 32'd0, 0, 0);
        wait_read();
        chk("jal_target", imem_address, 32'hB0000400);
        imem_waitrequest = 1'b1;
        @(negedge clk);
        chk("midwait_addr", imem_address, 32'hB0000400);
        do_reset();
        wait_read();
        chk("after_rst_addr", imem_address, RV);
        run_instr(32'h00000020, 0, 0, 0, 0, 32'd0, 0, 0);

        // Not-taken beq falls through.
        do_reset();
        run_instr(32'h10000003, 1, 0, 0, 0, 32'd0, 0, 0);
        run_instr(32'h00000000, 0, 0, 0, 0, 32'd0, 0, 0);
        wait_read();
        chk("beq_nt_addr", imem_address, 32'hBFC00008);

        // jr to address zero with a stalled execute, then halt after the delay slot.
        do_reset();
        run_instr(32'h03E00008, 0, 0, 0, 1, 32'd0, 0, 5);
        run_instr(32'h00000000, 1, 1, 0, 0, 32'd0, 0, 0);
        chkb("halt_model", m_halt, 1'b1);
        check_halted(6);

        // Random streams with random wait states, stalls and decoder requests.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            iw = $urandom;
            jr = ($urandom_range(0, 5) == 0);
            jp = ($urandom_range(0, 4) == 0);
            br = ($urandom_range(0, 2) == 0);
            cd = 1'($urandom_range(0, 1));
            rt = ($urandom_range(0, 14) == 0) ? 32'd0 : $urandom;
            run_instr(iw, br, cd, jp, jr, rt, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            if (m_halt) begin
                check_halted(3);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
